// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared state type, default burst length and counter width helper
package fifo_arb_pkg;
    typedef enum logic {IDLE, OWN} arb_state_t;
    localparam int DEF_MAX_BURST = 4;
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction
    localparam int DEF_BURST_W = cnt_w(DEF_MAX_BURST);
endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting after the last grant
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] idx;
    assign any_req = |req;
    // scan downward so the nearest requester after last is assigned last and wins
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the FIFO write port with bounded bursts.
// Define ARB_STATS_EN to add the saturating stall_cnt port (width CNT_W).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = DEF_MAX_BURST
`ifdef ARB_STATS_EN
    , parameter int CNT_W   = 8
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       fifo_write,
    output logic [WIDTH-1:0]           fifo_data,
    input  logic                       fifo_full,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
`ifdef ARB_STATS_EN
    , output logic [CNT_W-1:0]         stall_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = cnt_w(MAX_BURST);

    arb_state_t    state, state_n;
    logic [IW-1:0] owner_n, last, last_n, winner, sel;
    logic [BW-1:0] burst_cnt, burst_n, cur_cnt;
    logic          any_req, done;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

    // state register: grant state, owner, beat count and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            last      <= IW'(NUM_REQ - 1);
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            burst_cnt <= burst_n;
            last      <= last_n;
        end
    end

    // next state: IDLE grants (and may write beat 1); a burst ends on a dropped req or its final beat
    always_comb begin
        cur_cnt = state == IDLE ? '0 : burst_cnt;
        done    = fifo_write && cur_cnt == BW'(MAX_BURST - 1);
        state_n = state;
        owner_n = owner;
        last_n  = last;
        burst_n = burst_cnt;
        if (state == IDLE && any_req) begin
            state_n = OWN;
            owner_n = winner;
            burst_n = '0;
        end
        if (fifo_write) burst_n = cur_cnt + 1'b1;
        if ((state == OWN && !req[owner]) || done) begin
            state_n = IDLE;
            last_n  = owner_n;
            burst_n = '0;
        end
    end

    // outputs: zero-latency write strobe, held off by full and by reset
    always_comb begin
        fifo_write = reset_n & !fifo_full & (state == IDLE ? any_req : req[owner]);
        sel        = (state == IDLE && fifo_write) ? winner : owner;
        fifo_data  = req_data[int'(sel)*WIDTH +: WIDTH];
        ack        = fifo_write ? NUM_REQ'(1) << sel : '0;
        busy       = state == OWN;
    end

`ifdef ARB_STATS_EN
    // count cycles where someone wants to write but the FIFO is full, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt <= '0;
        else if (|req && fifo_full && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of burst, rotation, full stall, drop and reset behaviour
module tb_fifo_write_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_a, ack_a, req_b, ack_b;
    logic [15:0] rd_a, rd_b;
    logic       wr_a, wr_b, full_a, full_b, busy_a, busy_b;
    logic [7:0] fd_a, fd_b;
    logic       own_a, own_b;
`ifdef ARB_STATS_EN
    logic [1:0] stall_a;
    logic [7:0] stall_b;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ(2), .WIDTH(8), .MAX_BURST(4)
`ifdef ARB_STATS_EN
        , .CNT_W(2)
`endif
    ) u4 (
        .clk(clk), .reset_n(reset_n), .req(req_a), .req_data(rd_a), .ack(ack_a),
        .fifo_write(wr_a), .fifo_data(fd_a), .fifo_full(full_a), .owner(own_a), .busy(busy_a)
`ifdef ARB_STATS_EN
        , .stall_cnt(stall_a)
`endif
    );

    fifo_write_arbiter #(
        .NUM_REQ(2), .WIDTH(8), .MAX_BURST(1)
`ifdef ARB_STATS_EN
        , .CNT_W(8)
`endif
    ) u1 (
        .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(rd_b), .ack(ack_b),
        .fifo_write(wr_b), .fifo_data(fd_b), .fifo_full(full_b), .owner(own_b), .busy(busy_b)
`ifdef ARB_STATS_EN
        , .stall_cnt(stall_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; req_a = '0; req_b = '0; rd_a = '0; rd_b = '0; full_a = 1'b0; full_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_a = 2'b11; req_b = 2'b11;
        #1;
        chk("rst_wr", wr_a, 0); chk("rst_ack", ack_a, 0); chk("rst_busy", busy_a, 0);
        chk("rst_owner", own_a, 0); chk("rst_wr_b", wr_b, 0); chk("rst_ack_b", ack_b, 0);
`ifdef ARB_STATS_EN
        chk("rst_stall", stall_a, 0);
`endif
        req_a = '0; req_b = '0;
        reset_n = 1'b1;

        // single producer, bursts of 4 back to back
        rd_a = 16'h00C3; req_a = 2'b01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_wr", wr_a, 1); chk("t1_ack", ack_a, 2'b01); chk("t1_data", fd_a, 8'hC3);
            chk("t1_busy", busy_a, (k == 0 || k == 4) ? 0 : 1);
            tick();
        end
        req_a = '0;
        @(negedge clk); chk("t1_dead_wr", wr_a, 0); chk("t1_dead_busy", busy_a, 1);
        tick();
        @(negedge clk); chk("t1_idle_busy", busy_a, 0); chk("t1_idle_wr", wr_a, 0);
        tick();

        // producer 1 stalled by full after two beats
        rd_a = 16'h5A00; req_a = 2'b10;
        @(negedge clk); chk("t2_b1_ack", ack_a, 2'b10); chk("t2_b1_data", fd_a, 8'h5A);
        tick();
        @(negedge clk); chk("t2_b2_wr", wr_a, 1); chk("t2_b2_owner", own_a, 1); chk("t2_b2_busy", busy_a, 1);
        tick();
        full_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_full_wr", wr_a, 0); chk("t2_full_ack", ack_a, 0);
            chk("t2_full_owner", own_a, 1); chk("t2_full_busy", busy_a, 1);
            tick();
        end
        full_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_resume_wr", wr_a, 1); chk("t2_resume_ack", ack_a, 2'b10); chk("t2_resume_data", fd_a, 8'h5A);
            tick();
        end
        req_a = '0;
        @(negedge clk); chk("t2_end_busy", busy_a, 0); chk("t2_end_wr", wr_a, 0);
        tick();

        // producer 0 drops after one beat; producer 1 follows after a dead cycle
        rd_a = 16'h2211; req_a = 2'b11;
        @(negedge clk); chk("t3_p0_ack", ack_a, 2'b01); chk("t3_p0_data", fd_a, 8'h11);
        tick();
        req_a = 2'b10;
        @(negedge clk);
        chk("t3_dead_wr", wr_a, 0); chk("t3_dead_ack", ack_a, 0);
        chk("t3_dead_owner", own_a, 0); chk("t3_dead_busy", busy_a, 1);
        tick();
        req_a = 2'b11;
        @(negedge clk); chk("t3_p1_ack", ack_a, 2'b10); chk("t3_p1_data", fd_a, 8'h22); chk("t3_p1_busy", busy_a, 0);
        tick();
        req_a = '0;
        @(negedge clk); chk("t3_tail_wr", wr_a, 0);
        tick();

        // MAX_BURST=1 strict rotation
        rd_b = 16'h2211; req_b = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_wr", wr_b, 1);
            chk("t4_ack", ack_b, (k % 2) ? 2'b10 : 2'b01);
            chk("t4_data", fd_b, (k % 2) ? 8'h22 : 8'h11);
            tick();
        end
        req_b = '0;

        // reset in the middle of producer 1's burst
        req_a = 2'b10;
        @(negedge clk); chk("t5_b1_ack", ack_a, 2'b10);
        tick();
        @(negedge clk); chk("t5_b2_wr", wr_a, 1); chk("t5_b2_owner", own_a, 1); chk("t5_b2_busy", busy_a, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_wr", wr_a, 0); chk("t5_rst_ack", ack_a, 0);
        chk("t5_rst_busy", busy_a, 0); chk("t5_rst_owner", own_a, 0);
        req_a = 2'b11;
        #1;
        chk("t5_rst_req_wr", wr_a, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk); chk("t5_first_ack", ack_a, 2'b01); chk("t5_first_data", fd_a, 8'h11);
        tick();
        req_a = '0;
        tick();

`ifdef ARB_STATS_EN
        // stall counter saturates at 3 with CNT_W=2
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        full_a = 1'b1; req_a = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t6_stall", stall_a, (k < 2) ? k + 1 : 3);
            chk("t6_wr", wr_a, 0);
        end
        req_a = '0; full_a = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
